uart_tx_ctrl: RTL
=================

# uart_tx_ctrl

UART transmit controller that sequences the 8-bit serializer into a full UART frame (start bit, 8 data bits, optional parity, stop bit). It sits between the APB-side write path and the serial TX pin. It accepts bytes through a valid/ready handshake into a one-entry holding register and drives the serializer's enable. It muxes start, data, parity and stop levels onto the line, advancing only on the baud tick.

## Interface
- PAR_EN, 1: 1 = parity bit inserted after data; 0 = no parity bit.
- PAR_TYPE, 0: 0 = even parity, 1 = odd parity.

- CLK  in  1  system clock, all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- tx_en  in  1  baud tick, one-CLK pulse per bit period.
- P_DATA  in  8  byte to transmit.
- DATA_VALID  in  1  P_DATA valid.
- ready  out  1  holding register empty; byte is accepted on DATA_VALID & ready.
- ser_data  out  8  active byte, driven to the serializer Data input.
- ser_en  out  1  serializer EN.
- ser_done  in  1  serializer Done.
- ser_sdata  in  1  serializer SData.
- TX_OUT  out  1  serial line.
- busy  out  1  high in any state other than IDLE.

## Operation
- Registers:
  - hold_reg[7:0] and hold_full.
  - act_reg[7:0], which drives ser_data.
  - parity bit, computed when act_reg is loaded: even = ^byte, odd = ~^byte.
  - 3-bit state.
- Accept: DATA_VALID & ready loads hold_reg and sets hold_full. ready = ~hold_full.
- Transfer: hold_reg moves to act_reg on a tick in IDLE or STOP while hold_full = 1. That same edge clears hold_full.
  - Accept and transfer never coincide, because accept needs hold_full = 0.
- State machine. Every transition requires tx_en = 1, and each state lasts exactly one bit period.
  - IDLE: TX_OUT = 1. On tick with hold_full, transfer and go to START.
  - START: TX_OUT = 0. On tick, go to DATA.
  - DATA: ser_en = 1 and TX_OUT = ser_sdata. The serializer steps on each tick, bit 7 first.
    - On tick with ser_done = 1, go to PARITY if PAR_EN, else STOP.
    - The serializer reloads its count to 7 on that same tick.
  - PARITY: TX_OUT = parity bit. On tick, go to STOP.
  - STOP: TX_OUT = 1. On tick with hold_full, transfer and go to START (back-to-back, no idle bit). On tick without hold_full, go to IDLE.
- ser_en = 0 outside DATA, so the serializer holds count = 7 between frames.
- TX_OUT is combinational from the registered state, parity, and ser_sdata.
- A tick with no enabled transition has no effect.

## Timing
- Reset values: state IDLE, TX_OUT 1, busy 0, ready 1, ser_en 0, ser_data 0x00, hold_full 0.
- Reset mid-frame aborts immediately; TX_OUT returns to 1 asynchronously and the pending byte is lost.
- ready falls on the edge after acceptance and rises on the edge of the transfer tick.
- Latency, byte accepted in IDLE to start bit: TX_OUT falls on the first tick edge after acceptance.
  - If DATA_VALID and tx_en are high in the same cycle, the byte transmits on the following tick, not that one.
- Frame length: 11 bit periods with PAR_EN = 1, 10 with PAR_EN = 0.
- Back-to-back streaming gives continuous frames with no gap, provided each new byte is accepted before the STOP tick.
- DATA occupies exactly 8 ticks, bounded by ser_done. ser_done seen outside DATA is ignored.

## Test plan
- Reset: assert RST low mid-DATA -> TX_OUT = 1, busy = 0, ready = 1, ser_en = 0 at once. After release, the next byte frames correctly.
- Single byte, PAR_EN = 1, PAR_TYPE = 0, P_DATA = 0xA5 -> line over 11 ticks = 0, 1,0,1,0,0,1,0,1, 0 (parity), 1.
- PAR_TYPE = 1, P_DATA = 0x00 -> parity bit = 1. PAR_EN = 0, P_DATA = 0xFF -> 10-bit frame 0, 1×8, 1.
- Back-to-back: 0x3C then 0xC3, second byte given during the first frame's DATA state -> STOP tick goes directly to START, busy stays 1 across both frames, 22 contiguous bits.
- Back-pressure: three bytes offered back-to-back -> the first goes to act_reg. The second fills hold_reg and ready = 0, so the third is held until ready returns. All three transmit in order with no loss or duplication.
- Tick alignment: DATA_VALID in the same cycle as tx_en while IDLE -> no start bit that tick; start bit on the next tick, lasting a full bit period.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a byte as start, 8 data bits (MSB first via
// the external serializer), optional parity and stop, advancing on baud ticks.
module uart_tx_ctrl #(
    parameter bit PAR_EN   = 1'b1,
    parameter bit PAR_TYPE = 1'b0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       tx_en,
    input  logic [7:0] P_DATA,
    input  logic       DATA_VALID,
    output logic       ready,
    output logic [7:0] ser_data,
    output logic       ser_en,
    input  logic       ser_done,
    input  logic       ser_sdata,
    output logic       TX_OUT,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] act_q, act_d;
    logic       par_q, par_d;

    logic accept;
    logic load;

    // Holding-register handshake and transfer into the active register.
    always_comb begin
        accept      = DATA_VALID && !hold_full_q;
        load        = tx_en && hold_full_q && (state_q == S_IDLE || state_q == S_STOP);
        hold_d      = accept ? P_DATA : hold_q;
        hold_full_d = hold_full_q;
        if (accept) begin
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end
        act_d = load ? hold_q : act_q;
        par_d = load ? (PAR_TYPE ? ~^hold_q : ^hold_q) : par_q;
    end

    // Frame sequencing; every transition is gated by the baud tick.
    always_comb begin
        state_d = state_q;
        if (tx_en) begin
            case (state_q)
                S_IDLE:   if (hold_full_q) state_d = S_START;
                S_START:  state_d = S_DATA;
                S_DATA:   if (ser_done) state_d = PAR_EN ? S_PARITY : S_STOP;
                S_PARITY: state_d = S_STOP;
                S_STOP:   state_d = hold_full_q ? S_START : S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // FSM state and data registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            act_q       <= '0;
            par_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            act_q       <= act_d;
            par_q       <= par_d;
        end
    end

    // Line level muxed from the registered state.
    always_comb begin
        TX_OUT = 1'b1;
        case (state_q)
            S_IDLE:   TX_OUT = 1'b1;
            S_START:  TX_OUT = 1'b0;
            S_DATA:   TX_OUT = ser_sdata;
            S_PARITY: TX_OUT = par_q;
            S_STOP:   TX_OUT = 1'b1;
            default:  TX_OUT = 1'b1;
        endcase
    end

    assign ready    = ~hold_full_q;
    assign ser_data = act_q;
    assign ser_en   = (state_q == S_DATA);
    assign busy     = (state_q != S_IDLE);

endmodule
